pipelined_addsub: RTL and testbench

- Parametrised, pipelined two's-complement adder/subtractor; successor to the combinational ripple N-bit adder.
- The WIDTH-bit carry chain is split into STAGES equal segments, with a register between segments, so timing closes at wide widths.
- A valid/ready handshake on both sides lets it sit between streaming producers and consumers in the FPGA datapath.
- Adds a per-operation subtract mode, carry-out and signed-overflow flags.

---
 rtl/addsub_pkg.sv | 22 ++
 rtl/addsub_segment.sv | 22 ++
 rtl/pipelined_addsub.sv | 132 +++++++++++++
 tb/tb_pipelined_addsub.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: mode constants and configuration helpers
// shared by pipelined_addsub and its carry-chain segments.
package addsub_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  function automatic int seg_width(
    input int width,
    input int stages
  );
    return (stages > 0) ? width / stages : width;
  endfunction

  function automatic bit cfg_ok(
    input int width,
    input int stages
  );
    return (stages >= 1) && (width % stages == 0);
  endfunction

endpackage

// File: rtl/addsub_segment.sv
// addsub_segment: combinational SEG-bit slice of the carry chain,
// also exposing the carry into its top bit for overflow detection.
module addsub_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           msb_cin
);

  logic [SEG:0] full;

  assign full = {1'b0, a} + {1'b0, b} + (SEG+1)'(cin);
  assign sum  = full[SEG-1:0];
  assign cout = full[SEG];
  // sum bit = a ^ b ^ carry-in, so the carry-in falls out directly
  assign msb_cin = a[SEG-1] ^ b[SEG-1] ^ full[SEG-1];

endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: STAGES-deep carry-chain add/sub, valid/ready on both
// sides. ADDSUB_SATURATE_EN enables signed saturation of out_sum.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int SEG  = seg_width(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;

  logic [SEG-1:0] seg_a  [STAGES];
  logic [SEG-1:0] seg_b  [STAGES];
  logic [SEG-1:0] seg_s  [STAGES];
  logic           seg_ci [STAGES];
  logic           seg_co [STAGES];
  logic           seg_mc [STAGES];

  logic [WIDTH-1:0] opa_d [STAGES];
  logic [WIDTH-1:0] opa_q [STAGES];
  logic [WIDTH-1:0] opb_d [STAGES];
  logic [WIDTH-1:0] opb_q [STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];

  logic [STAGES-1:0] vld_d, vld_q;
  logic [STAGES-1:0] cy_d, cy_q;
  logic              ovf_d, ovf_q;

  assign out_valid = vld_q[LAST];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign b_eff     = (in_sub == SUB) ? ~in_b : in_b;

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    addsub_segment #(.SEG(SEG)) u_seg (
      .a       (seg_a[k]),
      .b       (seg_b[k]),
      .cin     (seg_ci[k]),
      .sum     (seg_s[k]),
      .cout    (seg_co[k]),
      .msb_cin (seg_mc[k])
    );
  end

  // Operands travel right-shifted so each stage
  // always consumes the bottom SEG bits.
  always_comb begin
    seg_a[0]  = in_a[SEG-1:0];
    seg_b[0]  = b_eff[SEG-1:0];
    seg_ci[0] = in_sub;
    for (int k = 1; k < STAGES; k++) begin
      seg_a[k]  = opa_q[k-1][SEG-1:0];
      seg_b[k]  = opb_q[k-1][SEG-1:0];
      seg_ci[k] = cy_q[k-1];
    end
  end

  // Sum segments enter at the top and drift down one
  // segment per stage, landing in place at the last stage.
  always_comb begin
    opa_d[0] = in_a >> SEG;
    opb_d[0] = b_eff >> SEG;
    sum_d[0] = WIDTH'(seg_s[0]) << (WIDTH - SEG);
    cy_d[0]  = seg_co[0];
    vld_d[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      opa_d[k] = opa_q[k-1] >> SEG;
      opb_d[k] = opb_q[k-1] >> SEG;
      sum_d[k] = (sum_q[k-1] >> SEG)
               | (WIDTH'(seg_s[k]) << (WIDTH - SEG));
      cy_d[k]  = seg_co[k];
      vld_d[k] = vld_q[k-1];
    end
    ovf_d = seg_mc[LAST] ^ seg_co[LAST];
`ifdef ADDSUB_SATURATE_EN
    if (ovf_d) begin
      sum_d[LAST] = sum_d[LAST][WIDTH-1]
                  ? {1'b0, {(WIDTH-1){1'b1}}}
                  : {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cy_q  <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        sum_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  assign out_sum  = sum_q[LAST];
  assign out_cout = cy_q[LAST];
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed and randomized checks of pipelined_addsub
// at WIDTH=32 with STAGES 1/2/4/8, plus a WIDTH=4 STAGES=2 instance.
module tb_pipelined_addsub;

  localparam int ND   = 5;
  localparam int MAIN = 2;
  localparam int SMALL = 4;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sub = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;

  logic        ir   [ND];
  logic        ov   [ND];
  logic        oc   [ND];
  logic        oo   [ND];
  logic [31:0] osum [ND];
  logic [3:0]  s4;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q [ND][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    pipelined_addsub #(.WIDTH(32), .STAGES(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (ir[g]),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .out_sum   (osum[g]),
      .out_cout  (oc[g]),
      .out_ovf   (oo[g])
    );
  end

  pipelined_addsub #(.WIDTH(4), .STAGES(2)) u_w4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (ir[SMALL]),
    .in_a      (in_a[3:0]),
    .in_b      (in_b[3:0]),
    .in_sub    (in_sub),
    .out_valid (ov[SMALL]),
    .out_ready (out_ready),
    .out_sum   (s4),
    .out_cout  (oc[SMALL]),
    .out_ovf   (oo[SMALL])
  );
  assign osum[SMALL] = {28'b0, s4};

  // Reference: exact integer arithmetic on unsigned and signed views.
  function automatic exp_t model(
    input int          w,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        sub
  );
    exp_t   e;
    longint m, h, ua, ub, sa, sb, r, sr;
    m  = longint'(1) << w;
    h  = m / 2;
    ua = longint'(a) % m;
    ub = longint'(b) % m;
    sa = (ua >= h) ? ua - m : ua;
    sb = (ub >= h) ? ub - m : ub;
    r  = sub ? ua - ub : ua + ub;
    sr = sub ? sa - sb : sa + sb;
    e.c = sub ? (ua >= ub) : (r >= m);
    e.o = (sr >= h) || (sr < -h);
    e.s = 32'(((r % m) + m) % m);
`ifdef ADDSUB_SATURATE_EN
    if (e.o) e.s = (sr > 0) ? 32'(h - 1) : 32'(h);
`endif
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0: return 32'hFFFF_FFFF;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if (ov[d] !== 1'b0 || osum[d] !== 32'h0 ||
          oc[d] !== 1'b0 || oo[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: v=%b s=%h c=%b o=%b, need 0/0/0/0",
                 d, ov[d], osum[d], oc[d], oo[d]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if (ir[d] !== 1'b1 || ov[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ready dut%0d: in_ready=%b out_valid=%b, need 1/0",
                 d, ir[d], ov[d]);
      end
    end
  endtask

  task automatic test_small();
    logic [31:0] es;
`ifdef ADDSUB_SATURATE_EN
    es = 32'h7;
`else
    es = 32'hC;
`endif
    do_reset();
    in_valid = 1'b1; in_a = 32'h7; in_b = 32'h5; in_sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (ov[SMALL] !== (c == 2)) begin
        n_fail++;
        $display("FAIL small_latency cycle%0d: out_valid=%b, need %b",
                 c, ov[SMALL], (c == 2));
      end
      if (c == 2) begin
        n_checks++;
        if (osum[SMALL] !== es || oc[SMALL] !== 1'b0 || oo[SMALL] !== 1'b1) begin
          n_fail++;
          $display("FAIL small_result: s=%h c=%b o=%b, need %h/0/1",
                   osum[SMALL], oc[SMALL], oo[SMALL], es);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    logic        tsub [3];
    logic [31:0] es [3];
    logic        ec [3];
    logic        eo [3];
    int          i;
    ta = '{32'hFFFF_FFFF, 32'd5, 32'h7FFF_FFFF};
    tb = '{32'd1, 32'd7, 32'd1};
    tsub = '{1'b0, 1'b1, 1'b0};
`ifdef ADDSUB_SATURATE_EN
    es = '{32'h0, 32'hFFFF_FFFE, 32'h7FFF_FFFF};
`else
    es = '{32'h0, 32'hFFFF_FFFE, 32'h8000_0000};
`endif
    ec = '{1'b1, 1'b0, 1'b0};
    eo = '{1'b0, 1'b0, 1'b1};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_a = ta[k]; in_b = tb[k]; in_sub = tsub[k];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int c = 3; c <= 7; c++) begin
      @(negedge clk);
      n_checks++;
      if (ov[MAIN] !== (c >= 4 && c <= 6)) begin
        n_fail++;
        $display("FAIL b2b_valid cycle%0d: out_valid=%b, need %b",
                 c, ov[MAIN], (c >= 4 && c <= 6));
      end
      if (c >= 4 && c <= 6) begin
        i = c - 4;
        n_checks++;
        if (osum[MAIN] !== es[i] || oc[MAIN] !== ec[i] || oo[MAIN] !== eo[i]) begin
          n_fail++;
          $display("FAIL b2b_result beat%0d: s=%h c=%b o=%b, need %h/%b/%b",
                   i, osum[MAIN], oc[MAIN], oo[MAIN], es[i], ec[i], eo[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int          nxt = 1;
    int          got = 1;
    int          stalls = 0;
    bit          held = 1'b0;
    logic [31:0] hsum = '0;
    do_reset();
    for (int cyc = 0; cyc < 60 && got <= 10; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 4 && cyc < 10);
      in_valid  = (nxt <= 10);
      in_a      = 32'(nxt);
      in_b      = 32'(2 * nxt);
      in_sub    = 1'b0;
      @(negedge clk);
      if (held) begin
        n_checks++;
        if (ov[MAIN] !== 1'b1 || osum[MAIN] !== hsum) begin
          n_fail++;
          $display("FAIL bp_hold: v=%b s=%h, need 1/%h", ov[MAIN], osum[MAIN], hsum);
        end
      end
      if (ov[MAIN] && !out_ready) begin
        stalls++;
        held = 1'b1;
        hsum = osum[MAIN];
        n_checks++;
        if (ir[MAIN] !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_in_ready: in_ready=%b, need 0", ir[MAIN]);
        end
      end else begin
        held = 1'b0;
      end
      if (ov[MAIN] && out_ready) begin
        n_checks++;
        if (osum[MAIN] !== 32'(3 * got)) begin
          n_fail++;
          $display("FAIL bp_order: s=%h, need %h", osum[MAIN], 32'(3 * got));
        end
        got++;
      end
      if (in_valid && ir[MAIN]) nxt++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (got != 11 || stalls == 0) begin
      n_fail++;
      $display("FAIL bp_count: results=%0d stalls=%0d, need 10 and >0",
               got - 1, stalls);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (ov[MAIN] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_extra: out_valid=%b s=%h, need 0", ov[MAIN], osum[MAIN]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_a = 32'(100 + k); in_b = 32'(k); in_sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if (ov[d] !== 1'b0 || osum[d] !== 32'h0) begin
        n_fail++;
        $display("FAIL midrst_clear dut%0d: v=%b s=%h, need 0/0", d, ov[d], osum[d]);
      end
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (ov[MAIN] !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_stale cycle%0d: out_valid=%b s=%h, need 0",
                 c, ov[MAIN], osum[MAIN]);
      end
    end
  endtask

  task automatic test_sweep();
    int   beats = 0;
    int   pend;
    bit   done = 1'b0;
    exp_t e;
    do_reset();
    for (int d = 0; d < ND; d++) q[d].delete();
    for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
      @(posedge clk); #1;
      if (beats < 1000) begin
        in_valid  = ($urandom_range(3) != 0);
        out_ready = ($urandom_range(3) != 0);
        in_sub    = 1'($urandom_range(1));
        in_a      = pick();
        in_b      = pick();
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      pend = 0;
      for (int d = 0; d < ND; d++) begin
        if (ov[d] && out_ready) begin
          n_checks++;
          if (q[d].size() == 0) begin
            n_fail++;
            $display("FAIL sweep_extra dut%0d: s=%h with no beat pending", d, osum[d]);
          end else begin
            e = q[d].pop_front();
            if (osum[d] !== e.s || oc[d] !== e.c || oo[d] !== e.o) begin
              n_fail++;
              $display("FAIL sweep_result dut%0d: s=%h c=%b o=%b, need %h/%b/%b",
                       d, osum[d], oc[d], oo[d], e.s, e.c, e.o);
            end
          end
        end
        if (in_valid && ir[d])
          q[d].push_back(model((d == SMALL) ? 4 : 32, in_a, in_b, in_sub));
        pend += q[d].size();
      end
      if (in_valid && ir[MAIN]) beats++;
      if (beats >= 1000 && pend == 0) done = 1'b1;
    end
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if (q[d].size() != 0) begin
        n_fail++;
        $display("FAIL sweep_drain dut%0d: %0d results missing, need 0",
                 d, q[d].size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
